fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the byte-addressable instruction memory. It owns the program counter, drives the memory address, captures the combinationally returned instruction word, and delivers it to decode through a 2-entry buffer with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch. Misaligned or out-of-range fetch addresses raise a sticky fault.

## Interface
Parameters:
- BASE_ADDR, 32'h01000000, reset PC and lowest legal instruction address
- MEM_BYTES, 32'h00010000, size of instruction region in bytes; legal PC range is BASE_ADDR .. BASE_ADDR+MEM_BYTES-4

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_address  out  32  byte address to instruction memory (combinational from PC)
- imem_read_write  out  1  tied 0; fetch never writes
- imem_data  in  32  instruction word returned combinationally for imem_address
- redirect  in  1  load new PC this cycle
- redirect_pc  in  32  target PC for redirect
- inst  out  32  instruction at buffer head
- inst_pc  out  32  PC of inst
- inst_valid  out  1  buffer head holds a valid instruction
- inst_ready  in  1  decode accepts head this cycle
- fault  out  1  sticky fetch fault
- fault_pc  out  32  offending PC, valid when fault=1

## Operation
- State machine: IDLE -> RUN -> FAULT. IDLE lasts exactly one cycle after reset deassertion, no fetch. FAULT is terminal until reset.
- Buffer: 2 entries of {pc, inst}, read/write pointers 1 bit each wrap modulo 2, count 0..2. inst/inst_pc/inst_valid come from head entry registers.
- Pop: inst_valid & inst_ready at the edge.
- Push (RUN only): when count<2, or count==2 and a pop occurs the same edge. Pushed entry = {pc, imem_data}; pc <= pc+4 (32-bit, wraps mod 2^32).
- Legality check at push time: pc[1:0]!=0, pc<BASE_ADDR, or pc>BASE_ADDR+MEM_BYTES-4 -> no push; state <= FAULT; fault<=1; fault_pc<=pc. Already-buffered entries remain deliverable.
- Redirect (any state except FAULT) has priority over push and pop: buffer flushed (count<=0, pointers<=0), pc<=redirect_pc, no push, no pop that edge. Legality of redirect_pc checked on the following cycle's push attempt.
- Redirect in IDLE: pc loaded, transition to RUN still occurs.
- In FAULT: redirect ignored; no further fetch; pops continue until empty.
- imem_address = pc at all times; imem_read_write = 0.

## Timing
- Reset values: pc=BASE_ADDR, count=0, inst_valid=0, inst=0, inst_pc=0, fault=0, fault_pc=0, state=IDLE, imem_address=BASE_ADDR.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), buffer contents discarded.
- Edge E0: first edge with reset_n high -> RUN. E1: first push. inst_valid=1 after E1. Fetch-to-valid latency: 1 cycle.
- Sustained throughput: 1 instruction/cycle with inst_ready held high.
- inst_ready low: buffer fills after two pushes; pc stalls at third address; no instruction lost or duplicated.
- Redirect at edge N: inst_valid=0 after N; target instruction valid after N+1.
- Handshake: inst/inst_pc stable while inst_valid=1 and inst_ready=0.
- Fault: fault rises after the edge at which the illegal push is attempted.

## Test plan
- Reset and stream: memory words 0x00000013, 0x00100093, 0x00200113 at 0x01000000..0x01000008, inst_ready=1 -> inst_valid first high after 2nd edge post-reset; inst_pc 0x01000000, 0x01000004, 0x01000008 on consecutive cycles with matching inst.
- Backpressure: inst_ready=0 for 5 cycles then 1 -> pc holds at 0x01000008, count=2, inst_pc sequence 0x01000000, 0x01000004, 0x01000008 with no gaps or repeats.
- Redirect with full buffer: count=2, redirect=1, redirect_pc=0x01000100 -> inst_valid=0 next cycle; next valid inst_pc=0x01000100.
- Simultaneous redirect and pop: inst_valid=inst_ready=redirect=1 -> head not treated as consumed beyond flush; next delivered inst_pc=redirect_pc.
- Misaligned redirect: redirect_pc=0x01000102 -> fault=1, fault_pc=0x01000102 one cycle later, inst_valid stays 0, later redirect ignored.
- Out-of-range run-off and async reset: sequential fetch to 0x0100FFFC then 0x01010000 -> fault_pc=0x01010000 after last legal entry is delivered; reset_n low mid-cycle -> fault=0, inst_valid=0, imem_address=0x01000000 immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, fetches one word per cycle from the
// instruction memory and hands it to decode through a 2-entry buffer.
// Redirects flush the buffer; an illegal fetch address parks the unit in a
// sticky fault state until reset.
module fetch_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h01000000,
  parameter logic [31:0] MEM_BYTES = 32'h00010000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  // Highest address at which a whole 4-byte word still fits in the region.
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + MEM_BYTES - 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [1:0]  count_reg, count_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        fault_reg, fault_next;
  logic [31:0] fault_pc_reg, fault_pc_next;

  logic [31:0] buf_pc_reg   [2];
  logic [31:0] buf_inst_reg [2];

  logic do_redirect;
  logic do_pop;
  logic push_try;
  logic pc_legal;
  logic do_push;

  // Handshake and fetch decisions for this edge; redirect overrides both
  // push and pop, but is ignored once faulted.
  always_comb begin
    do_redirect = redirect && (state_reg != ST_FAULT);
    do_pop      = inst_valid && inst_ready && !do_redirect;
    push_try    = (state_reg == ST_RUN) && !do_redirect &&
                  ((count_reg != 2'd2) || do_pop);
    pc_legal    = (pc_reg[1:0] == 2'b00) &&
                  (pc_reg >= BASE_ADDR) && (pc_reg <= LAST_ADDR);
    do_push     = push_try && pc_legal;
  end

  // Next-state logic: PC sequencing, fault capture and FSM transitions.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    fault_next    = fault_reg;
    fault_pc_next = fault_pc_reg;
    case (state_reg)
      ST_IDLE: begin
        // The idle cycle never fetches, but a redirect still lands.
        if (do_redirect) pc_next = redirect_pc;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (do_redirect) begin
          pc_next = redirect_pc;
        end else if (push_try && !pc_legal) begin
          state_next    = ST_FAULT;
          fault_next    = 1'b1;
          fault_pc_next = pc_reg;
        end else if (do_push) begin
          pc_next = pc_reg + 32'd4;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Buffer occupancy and pointer bookkeeping.
  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (do_redirect) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      count_next = count_reg + {1'b0, do_push} - {1'b0, do_pop};
      if (do_push) wr_ptr_next = ~wr_ptr_reg;
      if (do_pop)  rd_ptr_next = ~rd_ptr_reg;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= BASE_ADDR;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fault_reg    <= 1'b0;
      fault_pc_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      count_reg    <= count_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      fault_reg    <= fault_next;
      fault_pc_reg <= fault_pc_next;
    end
  end

  // One register pair per buffer slot, written when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    localparam logic SLOT = 1'(gi);
    // Capture {pc, instruction} into this slot on a push.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        buf_pc_reg[gi]   <= 32'd0;
        buf_inst_reg[gi] <= 32'd0;
      end else if (do_push && (wr_ptr_reg == SLOT)) begin
        buf_pc_reg[gi]   <= pc_reg;
        buf_inst_reg[gi] <= imem_data;
      end
    end
  end

  assign imem_address    = pc_reg;
  assign imem_read_write = 1'b0;
  assign inst            = buf_inst_reg[rd_ptr_reg];
  assign inst_pc         = buf_pc_reg[rd_ptr_reg];
  assign inst_valid      = (count_reg != 2'd0);
  assign fault           = fault_reg;
  assign fault_pc        = fault_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based model of the fetch stage.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h01000000;
  localparam logic [31:0] MEMB = 32'h00010000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        fault;
  logic [31:0] fault_pc;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fetch_unit #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_address   (imem_address),
    .imem_read_write(imem_read_write),
    .imem_data      (imem_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Instruction memory contents: three fixed words at the base, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == BASE)              return 32'h00000013;
    if (a == BASE + 32'd4)      return 32'h00100093;
    if (a == BASE + 32'd8)      return 32'h00200113;
    return {a[15:0] ^ 16'h5a5a, a[31:16] + a[7:0]};
  endfunction

  assign imem_data = mem_word(imem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_faulted;
  logic [31:0] m_fault_pc;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a <= BASE + MEMB - 32'd4);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_pc       = BASE;
      m_started  = 0;
      m_faulted  = 0;
      m_fault_pc = 32'd0;
    end else if (!m_started) begin
      if (redirect) m_pc = redirect_pc;
      m_started = 1;
    end else if (redirect && !m_faulted) begin
      mq.delete();
      m_pc = redirect_pc;
    end else begin
      int  n;
      bit  popped;
      n      = mq.size();
      popped = (n > 0) && inst_ready;
      if (popped) void'(mq.pop_front());
      if (!m_faulted && (n < 2 || popped)) begin
        if (legal(m_pc)) begin
          mq.push_back('{pc: m_pc, ins: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end else begin
          m_faulted  = 1;
          m_fault_pc = m_pc;
        end
      end
    end
  end

  // Compare DUT outputs against the model every cycle out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("imem_address", imem_address, m_pc);
      chk("imem_rw", 32'(imem_read_write), 32'd0);
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst", inst, mq[0].ins);
      end
      chk("fault", 32'(fault), 32'(m_faulted));
      if (m_faulted) chk("fault_pc", fault_pc, m_fault_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect = 1'b0;
    step(3);
    reset_n = 1'b1;
  endtask

  initial begin
    bit seen;

    // Reset values, then a plain stream with decode always ready.
    inst_ready = 1'b1;
    step(2);
    chk("rst inst_valid", 32'(inst_valid), 32'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst inst_pc", inst_pc, 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst fault_pc", fault_pc, 32'd0);
    chk("rst imem_address", imem_address, 32'h01000000);
    do_reset();
    step(1);
    chk("E0 inst_valid", 32'(inst_valid), 32'd0);
    step(1);
    chk("stream pc0", inst_pc, 32'h01000000);
    chk("stream inst0", inst, 32'h00000013);
    step(1);
    chk("stream pc1", inst_pc, 32'h01000004);
    chk("stream inst1", inst, 32'h00100093);
    step(1);
    chk("stream pc2", inst_pc, 32'h01000008);
    chk("stream inst2", inst, 32'h00200113);

    // Backpressure from reset: buffer fills, pc stalls at third address.
    inst_ready = 1'b0;
    do_reset();
    step(5);
    chk("bp imem_address", imem_address, 32'h01000008);
    chk("bp head pc", inst_pc, 32'h01000000);
    inst_ready = 1'b1;
    step(1);
    chk("bp pc1", inst_pc, 32'h01000004);
    step(1);
    chk("bp pc2", inst_pc, 32'h01000008);

    // Redirect with a full buffer.
    inst_ready = 1'b0;
    step(2);
    redirect = 1'b1;
    redirect_pc = 32'h01000100;
    step(1);
    redirect = 1'b0;
    chk("redir flush valid", 32'(inst_valid), 32'd0);
    step(1);
    chk("redir target valid", 32'(inst_valid), 32'd1);
    chk("redir target pc", inst_pc, 32'h01000100);

    // Redirect in the same cycle as a pop.
    inst_ready = 1'b1;
    step(2);
    redirect = 1'b1;
    redirect_pc = 32'h01000200;
    step(1);
    redirect = 1'b0;
    chk("redir+pop valid", 32'(inst_valid), 32'd0);
    step(1);
    chk("redir+pop pc", inst_pc, 32'h01000200);

    // Randomized traffic with legal redirect targets.
    for (int i = 0; i < 1500; i++) begin
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = BASE + (32'($urandom_range(0, 8191)) << 2);
      step(1);
    end
    redirect = 1'b0;

    // Misaligned redirect faults on the following push attempt.
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h01000102;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("misalign fault", 32'(fault), 32'd1);
    chk("misalign fault_pc", fault_pc, 32'h01000102);
    chk("misalign valid", 32'(inst_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h01000000;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("fault ignores redirect", imem_address, 32'h01000102);
    chk("fault sticky", 32'(fault), 32'd1);

    // Run off the end of the region; redirect issued during the idle cycle.
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0100FFF0;
    inst_ready = 1'b0;
    step(1);
    redirect = 1'b0;
    step(2);
    inst_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (fault) seen = 1;
    end
    chk("runoff fault seen", 32'(seen), 32'd1);
    chk("runoff fault_pc", fault_pc, 32'h01010000);
    chk("runoff last head", inst_pc, 32'h0100FFFC);
    chk("runoff last valid", 32'(inst_valid), 32'd1);
    step(1);
    chk("runoff drained", 32'(inst_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async fault", 32'(fault), 32'd0);
    chk("async valid", 32'(inst_valid), 32'd0);
    chk("async imem_address", imem_address, 32'h01000000);
    step(2);

    // Redirect below the region.
    reset_n = 1'b1;
    step(1);
    redirect = 1'b1;
    redirect_pc = 32'h00FFFFFC;
    step(1);
    redirect = 1'b0;
    step(1);
    chk("low fault", 32'(fault), 32'd1);
    chk("low fault_pc", fault_pc, 32'h00FFFFFC);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
